// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CR16-style multi-cycle control unit.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_LD, S_LD_WB,
        S_MEM_ST, S_SCOND, S_BRANCH, S_NEXT, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_NOP, C_LOAD, C_STOR, C_SCOND, C_JCOND, C_BCOND, C_ILL
    } iclass_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_CMP = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_LSH = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd10;

    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Fixed-width control outputs, registered as one word.
    typedef struct packed {
        logic       pc_en;
        logic       reg_en;
        logic       ram_en;
        logic       mem_req;
        logic       imm_sel;
        logic       sgn;
        logic       ram_addr_sel;
        logic [1:0] load_in_sel;
        logic [1:0] pc_state;
        logic [3:0] alu_op;
    } ctrl_t;

    // Opcodes/extensions shared by the R-type ext field and the I-type op field.
    function automatic logic is_alu_code(input logic [3:0] x);
        logic r;
        case (x)
            4'b0101, 4'b0110, 4'b0111, 4'b1110, 4'b1001,
            4'b1010, 4'b1011, 4'b0001, 4'b0010, 4'b0011: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] alu_map(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'b0101, 4'b0110, 4'b0111: r = ALU_ADD;
            4'b1110:                   r = ALU_MUL;
            4'b1001, 4'b1010:          r = ALU_SUB;
            4'b1011:                   r = ALU_CMP;
            4'b0001:                   r = ALU_AND;
            4'b0010:                   r = ALU_OR;
            4'b0011:                   r = ALU_XOR;
            4'b1000:                   r = ALU_LSH;
            default:                   r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic iclass_t classify(input logic [15:0] ir);
        iclass_t    c;
        logic [3:0] op;
        logic [3:0] ext;
        op  = ir[15:12];
        ext = ir[7:4];
        c   = C_ILL;
        if (op == 4'b0000) begin
            if (ext == 4'b0000)      c = C_NOP;
            else if (is_alu_code(ext)) c = C_R;
        end else if (is_alu_code(op) || op == 4'b1000) begin
            c = C_I;
        end else if (op == 4'b0100) begin
            case (ext)
                4'b0000: c = C_LOAD;
                4'b0100: c = C_STOR;
                4'b1101: c = C_SCOND;
                4'b1100: c = C_JCOND;
                default: c = C_ILL;
            endcase
        end else if (op == 4'b1100) begin
            c = C_BCOND;
        end
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_cond_eval.sv
// Branch/Scond condition evaluation against the saved flag register.
module cond_eval
    import cpu_ctrl_pkg::*;
#(
    parameter int FLAG_W = 5
) (
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);
    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    // Map the 4-bit condition code onto a flag expression.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ: taken = z;
            CC_NE: taken = ~z;
            CC_CS: taken = c;
            CC_CC: taken = ~c;
            CC_HI: taken = l;
            CC_LS: taken = ~l;
            CC_GT: taken = n;
            CC_LE: taken = ~n;
            CC_FS: taken = f;
            CC_FC: taken = ~f;
            CC_LO: taken = ~(l | z);
            CC_HS: taken = l | z;
            CC_LT: taken = ~(n | z);
            CC_GE: taken = n | z;
            CC_UC: taken = 1'b1;
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode, ALU, memory handshake with
// timeout, branches and a sticky trap. Outputs are registered from the
// next state so they are valid from the edge that enters each state.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 8,
    parameter int FLAG_W     = 5,
    parameter int TIMEOUT_W  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [15:0]           Instr,
    input  logic [FLAG_W-1:0]     ALUFlags,
    input  logic                  Stall,
    input  logic                  MemReady,
    output logic                  PCEn,
    output logic                  RegEn,
    output logic                  RAMEn,
    output logic                  MemReq,
    output logic                  ImmSel,
    output logic                  Signed,
    output logic                  RamAddrSelect,
    output logic [1:0]            LoadInSelect,
    output logic [1:0]            PCState,
    output logic [3:0]            ALUOpCode,
    output logic [REG_ADDR_W-1:0] RdestRegLoc,
    output logic [REG_ADDR_W-1:0] RsrcRegLoc,
    output logic [IMM_W-1:0]      Imm,
    output logic                  Trap
);
    state_t                state_q, state_d;
    logic [15:0]           ir_q, ir_d;
    logic [FLAG_W-1:0]     flags_q, flags_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rdest_q, rdest_d, rsrc_q, rsrc_d;
    logic [IMM_W-1:0]      imm_q, imm_d;
    logic                  trap_q, trap_d;
    iclass_t               cls_n;
    logic [3:0]            cond_n;
    logic                  taken;

    // Output decode is done on the next IR, so evaluate its condition here.
    assign cls_n  = classify(ir_d);
    assign cond_n = (cls_n == C_SCOND) ? ir_d[3:0] : ir_d[11:8];

    cond_eval #(.FLAG_W(FLAG_W)) u_cond (
        .cond  (cond_n),
        .flags (flags_q),
        .taken (taken)
    );

    // State, IR, saved flags, wait counter and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            rdest_q <= '0;
            rsrc_q  <= '0;
            imm_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            rdest_q <= rdest_d;
            rsrc_q  <= rsrc_d;
            imm_q   <= imm_d;
            trap_q  <= trap_d;
        end
    end

    // Next-state, IR capture, flag capture and memory wait counter.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            S_FETCH: if (!Stall) begin
                ir_d    = Instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cnt_d = '0;
                case (classify(ir_q))
                    C_R:              state_d = S_EXEC_R;
                    C_I:              state_d = S_EXEC_I;
                    C_LOAD:           state_d = S_MEM_LD;
                    C_STOR:           state_d = S_MEM_ST;
                    C_SCOND:          state_d = S_SCOND;
                    C_BCOND, C_JCOND: state_d = S_BRANCH;
                    C_NOP:            state_d = S_NEXT;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                flags_d = ALUFlags;
                state_d = S_NEXT;
            end
            // A ready response in the final wait cycle beats the timeout.
            S_MEM_LD, S_MEM_ST: begin
                if (MemReady)             state_d = (state_q == S_MEM_LD) ? S_LD_WB : S_NEXT;
                else if (cnt_inc == '1)   state_d = S_TRAP;
                else                      cnt_d   = cnt_inc;
            end
            S_LD_WB, S_SCOND:   state_d = S_NEXT;
            S_BRANCH, S_NEXT:   state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the state being entered.
    always_comb begin
        ctrl_d  = '0;
        rdest_d = '0;
        rsrc_d  = '0;
        imm_d   = '0;
        trap_d  = 1'b0;
        case (state_d)
            S_DECODE: begin
                rdest_d = REG_ADDR_W'(ir_d[11:8]);
                rsrc_d  = REG_ADDR_W'(ir_d[3:0]);
            end
            S_EXEC_R: begin
                rdest_d       = REG_ADDR_W'(ir_d[11:8]);
                rsrc_d        = REG_ADDR_W'(ir_d[3:0]);
                ctrl_d.alu_op = alu_map(ir_d[7:4]);
                ctrl_d.reg_en = (alu_map(ir_d[7:4]) != ALU_CMP);
            end
            S_EXEC_I: begin
                rdest_d        = REG_ADDR_W'(ir_d[11:8]);
                rsrc_d         = REG_ADDR_W'(ir_d[3:0]);
                ctrl_d.alu_op  = alu_map(ir_d[15:12]);
                ctrl_d.reg_en  = (alu_map(ir_d[15:12]) != ALU_CMP);
                ctrl_d.imm_sel = 1'b1;
                ctrl_d.sgn     = (ir_d[15:12] != 4'b0110);
                imm_d          = IMM_W'(ir_d[7:0]);
            end
            S_MEM_LD, S_LD_WB: begin
                rdest_d             = REG_ADDR_W'(ir_d[11:8]);
                rsrc_d              = REG_ADDR_W'(ir_d[3:0]);
                ctrl_d.mem_req      = (state_d == S_MEM_LD);
                ctrl_d.reg_en       = (state_d == S_LD_WB);
                ctrl_d.ram_addr_sel = 1'b1;
                ctrl_d.load_in_sel  = 2'b01;
            end
            S_MEM_ST: begin
                rdest_d             = REG_ADDR_W'(ir_d[11:8]);
                rsrc_d              = REG_ADDR_W'(ir_d[3:0]);
                ctrl_d.mem_req      = 1'b1;
                ctrl_d.ram_en       = 1'b1;
                ctrl_d.ram_addr_sel = 1'b1;
            end
            S_SCOND: begin
                rdest_d            = REG_ADDR_W'(ir_d[11:8]);
                ctrl_d.reg_en      = 1'b1;
                ctrl_d.load_in_sel = 2'b10;
                imm_d              = IMM_W'(taken);
            end
            S_BRANCH: begin
                ctrl_d.pc_en = 1'b1;
                if (cls_n == C_BCOND) begin
                    ctrl_d.pc_state = taken ? 2'b01 : 2'b00;
                    ctrl_d.sgn      = 1'b1;
                    imm_d           = IMM_W'(ir_d[7:0]);
                end else begin
                    ctrl_d.pc_state = taken ? 2'b10 : 2'b00;
                    rsrc_d          = REG_ADDR_W'(ir_d[3:0]);
                end
            end
            S_NEXT:  ctrl_d.pc_en = 1'b1;
            S_TRAP:  trap_d = 1'b1;
            default: ;
        endcase
    end

    assign PCEn          = ctrl_q.pc_en;
    assign RegEn         = ctrl_q.reg_en;
    assign RAMEn         = ctrl_q.ram_en;
    assign MemReq        = ctrl_q.mem_req;
    assign ImmSel        = ctrl_q.imm_sel;
    assign Signed        = ctrl_q.sgn;
    assign RamAddrSelect = ctrl_q.ram_addr_sel;
    assign LoadInSelect  = ctrl_q.load_in_sel;
    assign PCState       = ctrl_q.pc_state;
    assign ALUOpCode     = ctrl_q.alu_op;
    assign RdestRegLoc   = rdest_q;
    assign RsrcRegLoc    = rsrc_q;
    assign Imm           = imm_q;
    assign Trap          = trap_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for cpu_ctrl_fsm (default parameters).
module tb_cpu_ctrl_fsm;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [15:0] Instr;
    logic [4:0]  ALUFlags;
    logic        Stall, MemReady;
    logic        PCEn, RegEn, RAMEn, MemReq, ImmSel, Signed, RamAddrSelect, Trap;
    logic [1:0]  LoadInSelect, PCState;
    logic [3:0]  ALUOpCode, RdestRegLoc, RsrcRegLoc;
    logic [7:0]  Imm;

    typedef struct packed {
        logic       pc_en, reg_en, ram_en, mem_req, imm_sel, sgn, ram_as;
        logic [1:0] lis, pcs;
        logic [3:0] alu, rd, rs;
        logic [7:0] imm;
        logic       trap;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    cpu_ctrl_fsm dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .ALUFlags(ALUFlags),
        .Stall(Stall), .MemReady(MemReady), .PCEn(PCEn), .RegEn(RegEn),
        .RAMEn(RAMEn), .MemReq(MemReq), .ImmSel(ImmSel), .Signed(Signed),
        .RamAddrSelect(RamAddrSelect), .LoadInSelect(LoadInSelect),
        .PCState(PCState), .ALUOpCode(ALUOpCode), .RdestRegLoc(RdestRegLoc),
        .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Trap(Trap)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t o_dec(input logic [15:0] i);
        obs_t e;
        e = '0;
        e.rd = i[11:8];
        e.rs = i[3:0];
        return e;
    endfunction

    function automatic obs_t o_pc(input logic [1:0] pcs);
        obs_t e;
        e = '0;
        e.pc_en = 1'b1;
        e.pcs = pcs;
        return e;
    endfunction

    task automatic push(input string t, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic chk(input string t, input obs_t e);
        logic [31:0] av, ev;
        av = {PCEn, RegEn, RAMEn, MemReq, ImmSel, Signed, RamAddrSelect, LoadInSelect,
              PCState, ALUOpCode, RdestRegLoc, RsrcRegLoc, Imm, Trap};
        ev = e;
        vectors++;
        assert (av === ev) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, av, ev);
        end
    endtask

    // One expected entry per clock edge, sampled 1 time unit after the edge.
    task automatic drain();
        obs_t  e;
        string t;
        while (exp_q.size() > 0) begin
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, e);
        end
    endtask

    task automatic alu_i(input string t, input logic [15:0] i, input logic [3:0] op,
                         input logic sg, input logic we);
        obs_t e;
        Instr = i;
        e = o_dec(i);
        push({t, "_dec"}, e);
        e.alu = op; e.reg_en = we; e.imm_sel = 1'b1; e.imm = i[7:0]; e.sgn = sg;
        push({t, "_exec"}, e);
        push({t, "_next"}, o_pc(2'b00));
        push({t, "_fetch"}, '0);
        drain();
    endtask

    task automatic bcond(input string t, input logic tk);
        obs_t e;
        Instr = 16'hC0FA;
        push({t, "_dec"}, o_dec(16'hC0FA));
        e = o_pc(tk ? 2'b01 : 2'b00);
        e.imm = 8'hFA; e.sgn = 1'b1;
        push({t, "_br"}, e);
        push({t, "_fetch"}, '0);
        drain();
    endtask

    task automatic async_reset(input string t);
        #2 Rst_n = 1'b0;
        #1 chk(t, '0);
    endtask

    initial begin
        obs_t e;
        Rst_n = 1'b0; Instr = '0; ALUFlags = '0; Stall = 1'b0; MemReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk("reset", '0);

        // ADD R5,R2: FETCH, DECODE, EXEC_R, NEXT.
        Instr = 16'h0552; Rst_n = 1'b1;
        push("add_dec", o_dec(16'h0552));
        e = o_dec(16'h0552); e.reg_en = 1'b1; e.alu = 4'd0;
        push("add_exec", e);
        push("add_next", o_pc(2'b00));
        push("add_fetch", '0);
        drain();

        // CMPI saves Z=1; live flags then flip so the branch must use saved ones.
        ALUFlags = 5'b01000;
        alu_i("cmpi_z1", 16'hB303, 4'd2, 1'b1, 1'b0);
        ALUFlags = 5'b10111;
        bcond("beq_taken", 1'b1);
        ALUFlags = 5'b00000;
        alu_i("cmpi_z0", 16'hB303, 4'd2, 1'b1, 1'b0);
        ALUFlags = 5'b11111;
        bcond("beq_not", 1'b0);

        // Scond NE with saved Z=0 writes 1.
        Instr = 16'h47D1;
        push("scond_dec", o_dec(16'h47D1));
        e = '0; e.reg_en = 1'b1; e.lis = 2'b10; e.imm = 8'h01; e.rd = 4'h7;
        push("scond_wb", e);
        push("scond_next", o_pc(2'b00));
        push("scond_fetch", '0);
        drain();

        // Jcond unconditional via R3.
        Instr = 16'h4EC3;
        push("jcond_dec", o_dec(16'h4EC3));
        e = o_pc(2'b10); e.rs = 4'h3;
        push("jcond_br", e);
        push("jcond_fetch", '0);
        drain();

        alu_i("addui", 16'h61F0, 4'd0, 1'b0, 1'b1);
        alu_i("lshi", 16'h8204, 4'd7, 1'b1, 1'b1);

        // LOAD with three not-ready cycles: MemReq for exactly four cycles.
        Instr = 16'h4307; MemReady = 1'b0;
        push("ld_dec", o_dec(16'h4307));
        e = o_dec(16'h4307); e.mem_req = 1'b1; e.ram_as = 1'b1; e.lis = 2'b01;
        for (int k = 0; k < 4; k++) push($sformatf("ld_wait%0d", k), e);
        drain();
        MemReady = 1'b1;
        e = o_dec(16'h4307); e.reg_en = 1'b1; e.ram_as = 1'b1; e.lis = 2'b01;
        push("ld_wb", e);
        push("ld_next", o_pc(2'b00));
        push("ld_fetch", '0);
        drain();

        // STOR: ready arrives in the 15th wait cycle, which still completes.
        Instr = 16'h4142; MemReady = 1'b0;
        push("st15_dec", o_dec(16'h4142));
        e = o_dec(16'h4142); e.mem_req = 1'b1; e.ram_en = 1'b1; e.ram_as = 1'b1;
        for (int k = 0; k < 15; k++) push($sformatf("st15_wait%0d", k), e);
        drain();
        MemReady = 1'b1;
        push("st15_next", o_pc(2'b00));
        push("st15_fetch", '0);
        drain();

        // STOR never ready: trap after 15 wait cycles, then sticky.
        Instr = 16'h4142; MemReady = 1'b0;
        push("sto_dec", o_dec(16'h4142));
        for (int k = 0; k < 15; k++) push($sformatf("sto_wait%0d", k), e);
        e = '0; e.trap = 1'b1;
        push("sto_trap", e);
        drain();
        MemReady = 1'b1; Stall = 1'b1; Instr = 16'h0552;
        push("trap_sticky0", e);
        push("trap_sticky1", e);
        drain();
        Stall = 1'b0; MemReady = 1'b0;
        async_reset("trap_reset");

        // Illegal opcode and illegal R-type extension both trap after DECODE.
        Instr = 16'hF123; Rst_n = 1'b1;
        push("ill_op_dec", o_dec(16'hF123));
        push("ill_op_trap", e);
        push("ill_op_stay", e);
        drain();
        async_reset("ill_op_reset");
        Instr = 16'h0545; Rst_n = 1'b1;
        push("ill_ext_dec", o_dec(16'h0545));
        push("ill_ext_trap", e);
        drain();
        async_reset("ill_ext_reset");

        // Reset in the middle of a store drops MemReq without waiting for an edge.
        Instr = 16'h4142; Rst_n = 1'b1;
        push("midacc_dec", o_dec(16'h4142));
        e = o_dec(16'h4142); e.mem_req = 1'b1; e.ram_en = 1'b1; e.ram_as = 1'b1;
        push("midacc_wait", e);
        drain();
        async_reset("midacc_reset");

        // Stall holds FETCH for five cycles; later Stall is ignored outside FETCH.
        Stall = 1'b1; Instr = 16'h0A13; Rst_n = 1'b1;
        for (int k = 0; k < 5; k++) push($sformatf("stall%0d", k), '0);
        drain();
        Stall = 1'b0;
        push("and_dec", o_dec(16'h0A13));
        drain();
        Stall = 1'b1;
        e = o_dec(16'h0A13); e.reg_en = 1'b1; e.alu = 4'd3;
        push("and_exec", e);
        push("and_next", o_pc(2'b00));
        push("and_fetch", '0);
        push("and_fetch_hold", '0);
        drain();
        Stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
